// File: rtl/object_plotter.sv
// Erases an object's old rectangle and draws its new one, one pixel per cycle,
// on the VGA adapter write port. Off-screen pixels use their cycle but are not plotted.
module object_plotter #(
  parameter int unsigned MAX_X     = 159,
  parameter int unsigned MAX_Y     = 119,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       startPlot,
  input  logic [7:0] newX,
  input  logic [6:0] newY,
  input  logic [7:0] oldX,
  input  logic [6:0] oldY,
  input  logic [7:0] sizeX,
  input  logic [6:0] sizeY,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_new_x, r_old_x, r_size_x, r_ox;
  logic [YW-1:0] r_new_y, r_old_y, r_size_y, r_oy;
  logic [CW-1:0] r_colour;

  state_t        w_state_nxt;
  logic [XW-1:0] w_new_x_nxt, w_old_x_nxt, w_size_x_nxt, w_ox_nxt;
  logic [YW-1:0] w_new_y_nxt, w_old_y_nxt, w_size_y_nxt, w_oy_nxt;
  logic [CW-1:0] w_colour_nxt;
  logic [XW-1:0] w_vga_x_nxt;
  logic [YW-1:0] w_vga_y_nxt;
  logic [CW-1:0] w_vga_colour_nxt;
  logic          w_plot_nxt, w_busy_nxt, w_done_nxt;

  logic [XW-1:0] w_base_x;
  logic [YW-1:0] w_base_y;
  logic [XW:0]   w_sum_x;
  logic [YW:0]   w_sum_y;
  logic          w_in_view, w_x_last, w_y_last;

  // Pixel address: one bit wider than the screen coordinate so it cannot wrap.
  assign w_base_x  = (r_state == ST_ERASE) ? r_old_x : r_new_x;
  assign w_base_y  = (r_state == ST_ERASE) ? r_old_y : r_new_y;
  assign w_sum_x   = (XW+1)'(w_base_x) + (XW+1)'(r_ox);
  assign w_sum_y   = (YW+1)'(w_base_y) + (YW+1)'(r_oy);
  assign w_in_view = (32'(w_sum_x) <= MAX_X) && (32'(w_sum_y) <= MAX_Y);
  assign w_x_last  = (r_ox == r_size_x - XW'(1));
  assign w_y_last  = (r_oy == r_size_y - YW'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_new_x    <= '0;
      r_new_y    <= '0;
      r_old_x    <= '0;
      r_old_y    <= '0;
      r_size_x   <= '0;
      r_size_y   <= '0;
      r_colour   <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_new_x    <= w_new_x_nxt;
      r_new_y    <= w_new_y_nxt;
      r_old_x    <= w_old_x_nxt;
      r_old_y    <= w_old_y_nxt;
      r_size_x   <= w_size_x_nxt;
      r_size_y   <= w_size_y_nxt;
      r_colour   <= w_colour_nxt;
      r_ox       <= w_ox_nxt;
      r_oy       <= w_oy_nxt;
      vga_x      <= w_vga_x_nxt;
      vga_y      <= w_vga_y_nxt;
      vga_colour <= w_vga_colour_nxt;
      vga_plot   <= w_plot_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_new_x_nxt      = r_new_x;
    w_new_y_nxt      = r_new_y;
    w_old_x_nxt      = r_old_x;
    w_old_y_nxt      = r_old_y;
    w_size_x_nxt     = r_size_x;
    w_size_y_nxt     = r_size_y;
    w_colour_nxt     = r_colour;
    w_ox_nxt         = r_ox;
    w_oy_nxt         = r_oy;
    w_vga_x_nxt      = vga_x;
    w_vga_y_nxt      = vga_y;
    w_vga_colour_nxt = vga_colour;
    w_plot_nxt       = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (startPlot) begin
          w_new_x_nxt  = newX;
          w_new_y_nxt  = newY;
          w_old_x_nxt  = oldX;
          w_old_y_nxt  = oldY;
          w_size_x_nxt = sizeX;
          w_size_y_nxt = sizeY;
          w_colour_nxt = colour;
          w_ox_nxt     = '0;
          w_oy_nxt     = '0;
          if (sizeX == '0 || sizeY == '0) begin
            w_state_nxt = ST_DONE;
          end else if (oldX == newX && oldY == newY) begin
            w_state_nxt = ST_DRAW;
          end else begin
            w_state_nxt = ST_ERASE;
          end
        end
      end

      // Row-major scan; the erase hands over to the draw with no idle cycle.
      ST_ERASE, ST_DRAW: begin
        w_vga_x_nxt      = w_sum_x[XW-1:0];
        w_vga_y_nxt      = w_sum_y[YW-1:0];
        w_vga_colour_nxt = (r_state == ST_ERASE) ? BG_COLOUR : r_colour;
        w_plot_nxt       = w_in_view;
        w_busy_nxt       = 1'b1;
        if (w_x_last) begin
          w_ox_nxt = '0;
          if (w_y_last) begin
            w_oy_nxt    = '0;
            w_state_nxt = (r_state == ST_ERASE) ? ST_DRAW : ST_DONE;
          end else begin
            w_oy_nxt = r_oy + YW'(1);
          end
        end else begin
          w_ox_nxt = r_ox + XW'(1);
        end
      end

      ST_DONE: begin
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_object_plotter.sv
// Bench for object_plotter: a queue-based per-cycle reference built from the
// request rules, directed corner cases with literal timing checks, then random traffic.
module tb_object_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       startPlot;
  logic [7:0] newX, oldX, sizeX;
  logic [6:0] newY, oldY, sizeY;
  logic [2:0] colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  object_plotter dut (
    .clk(clk), .resetn(resetn), .startPlot(startPlot),
    .newX(newX), .newY(newY), .oldX(oldX), .oldY(oldY),
    .sizeX(sizeX), .sizeY(sizeY), .colour(colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // kind: 0 = idle cycle, 1 = pixel cycle, 2 = done cycle
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       plot;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          plot_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int          done_cyc = -1, start_cyc = 0;
  logic [17:0] first_px, last_px;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void push_rect(input int bx, input int by, input int sx, input int sy,
                                    input logic [2:0] c);
    for (int j = 0; j < sy; j++) begin
      for (int i = 0; i < sx; i++) begin
        exp_t e;
        int   px, py;
        px     = bx + i;
        py     = by + j;
        e.kind = 2'd1;
        e.x    = 8'(px);
        e.y    = 7'(py);
        e.c    = c;
        e.plot = (px <= 159) && (py <= 119);
        q.push_back(e);
      end
    end
  endfunction

  always @(posedge clk) cyc++;

  // Reference: a request accepted when nothing is pending expands into its full cycle list.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
    end else if (startPlot && q.size() == 0) begin
      exp_t e;
      e = '0;
      q.push_back(e);
      if (sizeX != 0 && sizeY != 0) begin
        if (!(oldX == newX && oldY == newY))
          push_rect(int'(oldX), int'(oldY), int'(sizeX), int'(sizeY), 3'b000);
        push_rect(int'(newX), int'(newY), int'(sizeX), int'(sizeY), colour);
      end
      e.kind = 2'd2;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_x", 32'(vga_x), 0);
      chk("rst_y", 32'(vga_y), 0);
      chk("rst_colour", 32'(vga_colour), 0);
      chk("rst_plot", 32'(vga_plot), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      case (e.kind)
        2'd1: begin
          chk("px_x", 32'(vga_x), 32'(e.x));
          chk("px_y", 32'(vga_y), 32'(e.y));
          chk("px_colour", 32'(vga_colour), 32'(e.c));
          chk("px_plot", 32'(vga_plot), 32'(e.plot));
          chk("px_busy", 32'(busy), 1);
          chk("px_done", 32'(done), 0);
        end
        2'd2: begin
          chk("done_plot", 32'(vga_plot), 0);
          chk("done_busy", 32'(busy), 1);
          chk("done_done", 32'(done), 1);
        end
        default: begin
          chk("idle_plot", 32'(vga_plot), 0);
          chk("idle_busy", 32'(busy), 0);
          chk("idle_done", 32'(done), 0);
        end
      endcase
    end else begin
      chk("idle_plot", 32'(vga_plot), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
    end
    if (vga_plot === 1'b1) begin
      if (plot_cnt == 0) first_px = {vga_x, vga_y, vga_colour};
      last_px = {vga_x, vga_y, vga_colour};
      plot_cnt++;
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic scramble();
    newX   = 8'($urandom);
    newY   = 7'($urandom);
    oldX   = 8'($urandom);
    oldY   = 7'($urandom);
    sizeX  = 8'($urandom);
    sizeY  = 7'($urandom);
    colour = 3'($urandom);
  endtask

  task automatic do_start(input logic [7:0] nx, input logic [6:0] ny, input logic [7:0] ox,
                          input logic [6:0] oy, input logic [7:0] sx, input logic [6:0] sy,
                          input logic [2:0] c);
    @(negedge clk); #1;
    newX = nx; newY = ny; oldX = ox; oldY = oy; sizeX = sx; sizeY = sy; colour = c;
    startPlot = 1'b1;
    plot_cnt  = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
    done_cyc  = -1;
    start_cyc = cyc + 1;
    @(negedge clk); #1;
    startPlot = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    startPlot = 1'b0;
    newX = '0; newY = '0; oldX = '0; oldY = '0; sizeX = '0; sizeY = '0; colour = '0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Moved 4x4 object: 16 erase + 16 draw pixels, done at T+33.
    do_start(8'd11, 7'd21, 8'd10, 7'd20, 8'd4, 7'd4, 3'b111);
    wait_done(100);
    chk("t1_latency", 32'(done_cyc - start_cyc), 33);
    chk("t1_plots", 32'(plot_cnt), 32);
    chk("t1_first", 32'(first_px), 32'({8'd10, 7'd20, 3'd0}));
    chk("t1_last", 32'(last_px), 32'({8'd14, 7'd24, 3'd7}));

    // Stationary object: erase skipped.
    do_start(8'd50, 7'd60, 8'd50, 7'd60, 8'd16, 7'd1, 3'b101);
    wait_done(100);
    chk("t2_latency", 32'(done_cyc - start_cyc), 17);
    chk("t2_plots", 32'(plot_cnt), 16);
    chk("t2_first", 32'(first_px), 32'({8'd50, 7'd60, 3'd5}));
    chk("t2_last", 32'(last_px), 32'({8'd65, 7'd60, 3'd5}));

    // Zero width: done straight away, no pixels.
    do_start(8'd30, 7'd30, 8'd20, 7'd20, 8'd0, 7'd3, 3'b011);
    wait_done(20);
    chk("t3_latency", 32'(done_cyc - start_cyc), 1);
    chk("t3_plots", 32'(plot_cnt), 0);
    chk("t3_busy_cycles", 32'(busy_cnt), 1);

    // Draw straddling the bottom-right corner: 16 erase + 6 visible draw pixels.
    do_start(8'd157, 7'd118, 8'd100, 7'd100, 8'd4, 7'd4, 3'b010);
    wait_done(100);
    chk("t4_latency", 32'(done_cyc - start_cyc), 33);
    chk("t4_plots", 32'(plot_cnt), 22);
    chk("t4_last", 32'(last_px), 32'({8'd159, 7'd119, 3'd2}));

    // Second request in the middle of the draw phase is dropped.
    do_start(8'd11, 7'd21, 8'd10, 7'd20, 8'd4, 7'd4, 3'b111);
    repeat (20) @(negedge clk);
    #1;
    newX = 8'd0; newY = 7'd0; oldX = 8'd5; oldY = 7'd5; sizeX = 8'd2; sizeY = 7'd2;
    startPlot = 1'b1;
    @(negedge clk); #1;
    startPlot = 1'b0;
    wait_done(100);
    chk("t5_latency", 32'(done_cyc - start_cyc), 33);
    chk("t5_plots", 32'(plot_cnt), 32);
    chk("t5_done_pulses", 32'(done_cnt), 1);
    chk("t5_last", 32'(last_px), 32'({8'd14, 7'd24, 3'd7}));

    // Reset during the erase aborts the request outright.
    do_start(8'd11, 7'd21, 8'd10, 7'd20, 8'd4, 7'd4, 3'b111);
    repeat (4) @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("t6_async_x", 32'(vga_x), 0);
    chk("t6_async_y", 32'(vga_y), 0);
    chk("t6_async_plot", 32'(vga_plot), 0);
    chk("t6_async_busy", 32'(busy), 0);
    @(negedge clk); #1;
    resetn   = 1'b1;
    plot_cnt = 0;
    done_cnt = 0;
    repeat (30) @(negedge clk);
    #1;
    chk("t6_no_plots", 32'(plot_cnt), 0);
    chk("t6_no_done", 32'(done_cnt), 0);

    // Random traffic, including requests while busy and rectangles hitting the edges.
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk); #1;
      startPlot = ($urandom_range(0, 5) == 0);
      newX   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(150, 170)) : 8'($urandom_range(0, 255));
      newY   = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 127));
      oldX   = ($urandom_range(0, 3) == 0) ? newX : 8'($urandom_range(0, 255));
      oldY   = (oldX == newX) ? newY : 7'($urandom_range(0, 127));
      sizeX  = 8'($urandom_range(0, 6));
      sizeY  = 7'($urandom_range(0, 6));
      colour = 3'($urandom);
    end
    startPlot = 1'b0;
    repeat (120) @(negedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
